// File: rtl/mito_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mito_pkg
//  Description : Shared constants for the operand fetch buffer: layer type
//                codes, fetch state encoding and default fetch base addresses.
//  Revision    : 1.0  initial release
// ============================================================================
package mito_pkg;

    // Layer type codes driven by the layer controller
    localparam logic [1:0] c_LT_NONE        = 2'b00;
    localparam logic [1:0] c_LT_CONVOLUTION = 2'b01;
    localparam logic [1:0] c_LT_POOLING     = 2'b10;
    localparam logic [1:0] c_LT_FULLY       = 2'b11;

    // Fetch state machine encoding
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t c_ST_IDLE       = 2'd0;
    localparam fetch_state_t c_ST_FETCH_IFM  = 2'd1;
    localparam fetch_state_t c_ST_FETCH_WGT  = 2'd2;
    localparam fetch_state_t c_ST_FETCH_BIAS = 2'd3;

    // Default fetch base addresses
    localparam logic [15:0] c_IFM_BASE_DEF  = 16'h0000;
    localparam logic [15:0] c_WGT_BASE_DEF  = 16'h0400;
    localparam logic [15:0] c_BIAS_BASE_DEF = 16'h0800;

endpackage
`default_nettype wire

// File: rtl/fetch_bank.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_bank
//  Description : Local operand register bank. Sequential write pointer, full
//                flag, and a flattened read bus that already reflects the
//                word written this cycle (word 0 in the LSBs).
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_bank #(
    parameter int DEPTH  = 9,
    parameter int DATA_W = 16,
    parameter int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_start,
    input  logic                    i_wr_en,
    input  logic [DATA_W-1:0]       i_wr_data,
    input  logic                    i_clr_full,
    output logic [PTR_W-1:0]        o_ptr,
    output logic                    o_last,
    output logic                    o_full_next,
    output logic [DEPTH*DATA_W-1:0] o_rd_bus_next
);

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [PTR_W-1:0]  r_ptr;
    logic              r_full;
    logic              w_last;

    assign w_last = (r_ptr == PTR_W'(DEPTH - 1));

    // Pointer and full flag: burst start clears both, the final write sets
    // full, and a presentation clear overrides a same-cycle final write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr  <= '0;
            r_full <= 1'b0;
        end else begin
            if (i_start) begin
                r_ptr  <= '0;
                r_full <= 1'b0;
            end else if (i_wr_en) begin
                if (w_last) begin
                    r_ptr  <= '0;
                    r_full <= 1'b1;
                end else begin
                    r_ptr <= r_ptr + PTR_W'(1);
                end
            end
            if (i_clr_full) begin
                r_full <= 1'b0;
            end
        end
    end

    // Word storage, written at the current pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[r_ptr] <= i_wr_data;
        end
    end

    // Read bus with write-through so a same-cycle presentation sees the new word
    for (genvar g = 0; g < DEPTH; g++) begin : g_rd
        assign o_rd_bus_next[g*DATA_W +: DATA_W] =
            (i_wr_en && (r_ptr == PTR_W'(g))) ? i_wr_data : r_mem[g];
    end

    assign o_ptr       = r_ptr;
    assign o_last      = w_last;
    assign o_full_next = r_full | (i_wr_en & w_last);

endmodule
`default_nettype wire

// File: rtl/operand_fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : operand_fetch_buffer
//  Description : Fetches IFM window, kernel and bias words from on-chip memory
//                into three local banks on controller strobes, and presents a
//                complete operand set to the PE array on input_load.
//                Optional: MITO_FETCH_STALL_CNT_EN adds the stall_cnt output.
//  Revision    : 1.0  initial release
// ============================================================================
module operand_fetch_buffer
    import mito_pkg::*;
#(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 16,
    parameter int                IFM_WORDS = 9,
    parameter int                WGT_WORDS = 9,
    parameter logic [ADDR_W-1:0] IFM_BASE  = c_IFM_BASE_DEF,
    parameter logic [ADDR_W-1:0] WGT_BASE  = c_WGT_BASE_DEF,
    parameter logic [ADDR_W-1:0] BIAS_BASE = c_BIAS_BASE_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [1:0]                  layer_type,
    input  logic                        ifm_read,
    input  logic                        wgt_read,
    input  logic                        bias_read,
    input  logic                        input_load,
    output logic                        mem_req_valid,
    output logic [ADDR_W-1:0]           mem_req_addr,
    input  logic                        mem_req_ready,
    input  logic                        mem_rsp_valid,
    input  logic [DATA_W-1:0]           mem_rsp_data,
    output logic                        op_valid,
    input  logic                        op_ready,
    output logic [IFM_WORDS*DATA_W-1:0] op_ifm,
    output logic [WGT_WORDS*DATA_W-1:0] op_wgt,
    output logic [DATA_W-1:0]           op_bias,
    output logic [1:0]                  op_layer_type,
    output logic                        busy,
    output logic                        err
`ifdef MITO_FETCH_STALL_CNT_EN
    ,
    output logic [15:0]                 stall_cnt
`endif
);

    localparam int c_IFM_PW = (IFM_WORDS > 1) ? $clog2(IFM_WORDS) : 1;
    localparam int c_WGT_PW = (WGT_WORDS > 1) ? $clog2(WGT_WORDS) : 1;

    logic r_ifm_q, r_wgt_q, r_bias_q, r_load_q;
    logic r_pend_ifm, r_pend_wgt, r_pend_bias;
    logic r_wait_rsp;
    fetch_state_t r_state, w_state_next;

    logic w_pool, w_ifm_rise, w_wgt_rise, w_bias_rise, w_load_rise;
    logic w_rsp_take, w_cur_last;
    logic w_start_ifm, w_start_wgt, w_start_bias;
    logic w_we_ifm, w_we_wgt, w_we_bias;
    logic w_complete, w_present, w_err_set;

    logic [c_IFM_PW-1:0]         w_ifm_ptr;
    logic [c_WGT_PW-1:0]         w_wgt_ptr;
    logic                        w_bias_ptr;
    logic                        w_ifm_last, w_wgt_last, w_bias_last;
    logic                        w_ifm_full, w_wgt_full, w_bias_full;
    logic [IFM_WORDS*DATA_W-1:0] w_ifm_bus;
    logic [WGT_WORDS*DATA_W-1:0] w_wgt_bus;
    logic [DATA_W-1:0]           w_bias_bus;

    logic                        r_op_valid;
    logic [IFM_WORDS*DATA_W-1:0] r_op_ifm;
    logic [WGT_WORDS*DATA_W-1:0] r_op_wgt;
    logic [DATA_W-1:0]           r_op_bias;
    logic [1:0]                  r_op_layer_type;
    logic                        r_err;

    assign w_pool      = (layer_type == c_LT_POOLING);
    assign w_ifm_rise  = ifm_read   & ~r_ifm_q;
    assign w_wgt_rise  = wgt_read   & ~r_wgt_q;
    assign w_bias_rise = bias_read  & ~r_bias_q;
    assign w_load_rise = input_load & ~r_load_q;
    assign w_rsp_take  = r_wait_rsp & mem_rsp_valid & (r_state != c_ST_IDLE);

    // Strobe history for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ifm_q  <= 1'b0;
            r_wgt_q  <= 1'b0;
            r_bias_q <= 1'b0;
            r_load_q <= 1'b0;
        end else begin
            r_ifm_q  <= ifm_read;
            r_wgt_q  <= wgt_read;
            r_bias_q <= bias_read;
            r_load_q <= input_load;
        end
    end

    // Pending requests: cleared when the bank's burst starts; edges on a bank
    // already pending or fetching are dropped, and pooling ignores wgt/bias.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_ifm  <= 1'b0;
            r_pend_wgt  <= 1'b0;
            r_pend_bias <= 1'b0;
        end else begin
            if (w_start_ifm)
                r_pend_ifm <= 1'b0;
            else if (w_ifm_rise && (r_state != c_ST_FETCH_IFM))
                r_pend_ifm <= 1'b1;
            if (w_start_wgt)
                r_pend_wgt <= 1'b0;
            else if (w_wgt_rise && !w_pool && (r_state != c_ST_FETCH_WGT))
                r_pend_wgt <= 1'b1;
            if (w_start_bias)
                r_pend_bias <= 1'b0;
            else if (w_bias_rise && !w_pool && (r_state != c_ST_FETCH_BIAS))
                r_pend_bias <= 1'b1;
        end
    end

    // Fetch state register and single-outstanding request tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_wait_rsp <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (mem_req_valid && mem_req_ready)
                r_wait_rsp <= 1'b1;
            else if (w_rsp_take)
                r_wait_rsp <= 1'b0;
        end
    end

    // Next state: IDLE serves IFM > WGT > BIAS; a burst ends on its last word
    always_comb begin
        w_state_next = r_state;
        w_cur_last   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (r_pend_ifm)       w_state_next = c_ST_FETCH_IFM;
                else if (r_pend_wgt)  w_state_next = c_ST_FETCH_WGT;
                else if (r_pend_bias) w_state_next = c_ST_FETCH_BIAS;
            end
            c_ST_FETCH_IFM:  w_cur_last = w_ifm_last;
            c_ST_FETCH_WGT:  w_cur_last = w_wgt_last;
            default:         w_cur_last = w_bias_last;
        endcase
        if (w_rsp_take && w_cur_last)
            w_state_next = c_ST_IDLE;
    end

    // Outputs: request channel, bank write enables and burst starts
    always_comb begin
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        w_we_ifm      = 1'b0;
        w_we_wgt      = 1'b0;
        w_we_bias     = 1'b0;
        w_start_ifm   = 1'b0;
        w_start_wgt   = 1'b0;
        w_start_bias  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_start_ifm  = (w_state_next == c_ST_FETCH_IFM);
                w_start_wgt  = (w_state_next == c_ST_FETCH_WGT);
                w_start_bias = (w_state_next == c_ST_FETCH_BIAS);
            end
            c_ST_FETCH_IFM: begin
                mem_req_valid = ~r_wait_rsp;
                mem_req_addr  = IFM_BASE + ADDR_W'(w_ifm_ptr);
                w_we_ifm      = w_rsp_take;
            end
            c_ST_FETCH_WGT: begin
                mem_req_valid = ~r_wait_rsp;
                mem_req_addr  = WGT_BASE + ADDR_W'(w_wgt_ptr);
                w_we_wgt      = w_rsp_take;
            end
            default: begin
                mem_req_valid = ~r_wait_rsp;
                mem_req_addr  = BIAS_BASE + ADDR_W'(w_bias_ptr);
                w_we_bias     = w_rsp_take;
            end
        endcase
    end

    fetch_bank #(.DEPTH(IFM_WORDS), .DATA_W(DATA_W), .PTR_W(c_IFM_PW)) u_ifm_bank (
        .clk(clk), .rst_n(rst_n), .i_start(w_start_ifm), .i_wr_en(w_we_ifm),
        .i_wr_data(mem_rsp_data), .i_clr_full(w_present), .o_ptr(w_ifm_ptr),
        .o_last(w_ifm_last), .o_full_next(w_ifm_full), .o_rd_bus_next(w_ifm_bus)
    );

    fetch_bank #(.DEPTH(WGT_WORDS), .DATA_W(DATA_W), .PTR_W(c_WGT_PW)) u_wgt_bank (
        .clk(clk), .rst_n(rst_n), .i_start(w_start_wgt), .i_wr_en(w_we_wgt),
        .i_wr_data(mem_rsp_data), .i_clr_full(w_present), .o_ptr(w_wgt_ptr),
        .o_last(w_wgt_last), .o_full_next(w_wgt_full), .o_rd_bus_next(w_wgt_bus)
    );

    fetch_bank #(.DEPTH(1), .DATA_W(DATA_W), .PTR_W(1)) u_bias_bank (
        .clk(clk), .rst_n(rst_n), .i_start(w_start_bias), .i_wr_en(w_we_bias),
        .i_wr_data(mem_rsp_data), .i_clr_full(w_present), .o_ptr(w_bias_ptr),
        .o_last(w_bias_last), .o_full_next(w_bias_full), .o_rd_bus_next(w_bias_bus)
    );

    // A set is complete when every required bank is full, counting a final
    // word landing this very cycle.
    assign w_complete = w_ifm_full & (w_pool | (w_wgt_full & w_bias_full));
    assign w_present  = w_load_rise & ~r_op_valid & w_complete;
    assign w_err_set  = w_load_rise & (r_op_valid | ~w_complete);

    // Operand output registers, held until the PE array accepts them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_valid      <= 1'b0;
            r_op_ifm        <= '0;
            r_op_wgt        <= '0;
            r_op_bias       <= '0;
            r_op_layer_type <= 2'b00;
        end else if (w_present) begin
            r_op_valid      <= 1'b1;
            r_op_ifm        <= w_ifm_bus;
            r_op_wgt        <= w_pool ? '0 : w_wgt_bus;
            r_op_bias       <= w_pool ? '0 : w_bias_bus;
            r_op_layer_type <= layer_type;
        end else if (r_op_valid && op_ready) begin
            r_op_valid <= 1'b0;
        end
    end

    // Sticky protocol error, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_err <= 1'b0;
        else if (w_err_set)
            r_err <= 1'b1;
    end

`ifdef MITO_FETCH_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Count request cycles the memory refuses, saturating at all ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_cnt <= 16'h0000;
        else if (mem_req_valid && !mem_req_ready && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign op_valid      = r_op_valid;
    assign op_ifm        = r_op_ifm;
    assign op_wgt        = r_op_wgt;
    assign op_bias       = r_op_bias;
    assign op_layer_type = r_op_layer_type;
    assign err           = r_err;
    assign busy          = (r_state != c_ST_IDLE) | r_pend_ifm | r_pend_wgt | r_pend_bias;

endmodule
`default_nettype wire

// File: doc/operand_fetch_buffer.md
Name: operand_fetch_buffer

Overview:
- Sits directly downstream of the layer controller. Consumes its `layer_type`, `ifm_read`, `wgt_read`, `bias_read` and `input_load` strobes.
- Fetches IFM window, weight and bias words from on-chip memory over a valid/ready request channel and fills three local register banks.
- On `input_load`, presents a complete operand set to the PE array with a valid/ready handshake.

Parameters:
- DATA_W, 16, operand word width
- ADDR_W, 16, memory address width
- IFM_WORDS, 9, words per IFM window (3x3)
- WGT_WORDS, 9, words per kernel
- IFM_BASE, 16'h0000, IFM fetch base address
- WGT_BASE, 16'h0400, weight fetch base address
- BIAS_BASE, 16'h0800, bias fetch address (one word)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- layer_type  in  2  01 conv, 10 pool, 11 fully, 00 none
- ifm_read  in  1  level strobe from controller; rising edge requests IFM burst
- wgt_read  in  1  rising edge requests weight burst
- bias_read  in  1  rising edge requests bias fetch
- input_load  in  1  rising edge requests operand presentation
- mem_req_valid  out  1  read request valid
- mem_req_addr  out  ADDR_W  read address
- mem_req_ready  in  1  memory accepts request
- mem_rsp_valid  in  1  read data valid (in order)
- mem_rsp_data  in  DATA_W  read data
- op_valid  out  1  operand set valid to PE array
- op_ready  in  1  PE array accepts operands
- op_ifm  out  IFM_WORDS*DATA_W  word 0 in LSBs
- op_wgt  out  WGT_WORDS*DATA_W  word 0 in LSBs
- op_bias  out  DATA_W  bias
- op_layer_type  out  2  layer_type sampled at presentation
- busy  out  1  fetch FSM not IDLE or any request pending
- err  out  1  sticky protocol error flag

Behaviour:
- Reset (async, rst_n low): all outputs 0; banks, pointers, pending bits and full flags cleared; FSM to IDLE. Reset asserted mid-burst drops `mem_req_valid` immediately. Responses arriving after reset release are discarded while in IDLE.
- Edge detect: each strobe is registered. Rising edge sets that bank's pending bit.
  - A rising edge on a bank already pending or fetching is ignored.
  - During POOLING, `wgt_read`/`bias_read` edges are ignored.
- FSM states: IDLE, FETCH_IFM, FETCH_WGT, FETCH_BIAS.
  - IDLE picks the highest-priority pending bank: IFM > WGT > BIAS. Clears its pending bit, resets its word pointer, enters the matching FETCH state.
- Fetch protocol: one outstanding request at a time.
  - `mem_req_valid`=1 with `mem_req_addr` = base + pointer until `mem_req_ready`. Then `mem_req_valid`=0 until `mem_rsp_valid`.
  - Data is written at the pointer, then the pointer increments.
  - After the last word (IFM_WORDS, WGT_WORDS or 1), set the bank full flag and return to IDLE.
  - Minimum 2 cycles per word. Address arithmetic is ADDR_W-bit modulo (wraps).
- Refetch into a full bank overwrites it. The full flag clears at burst start and sets again at burst end.
- Presentation on `input_load` rising edge:
  - Complete means all three full flags set. In POOLING, only the IFM full flag is required; `op_wgt` and `op_bias` present 0.
  - If complete and `op_valid`=0: next cycle `op_ifm`/`op_wgt`/`op_bias`/`op_layer_type` are latched, `op_valid`=1, and the full flags clear.
  - If incomplete: set `err`; no presentation.
- Operand handshake: `op_valid` and the op data are held stable until `op_valid&&op_ready`; `op_valid` drops next cycle.
  - A `input_load` edge while `op_valid`=1 sets `err` and is ignored.
  - Fetching into the banks continues while `op_valid` is held; output registers are separate from the banks.
- Same-cycle `input_load` edge and last-word write to a bank: presentation uses the updated full flag, i.e. it succeeds.
- `err` clears only on reset.
- `busy` = (state!=IDLE) | (|pending).

Optional Feature:
- Macro MITO_FETCH_STALL_CNT_EN.
  - Defined: adds output port `stall_cnt` [15:0]. Counts cycles with `mem_req_valid && !mem_req_ready`, saturating at 16'hFFFF, reset 0.
  - Undefined: the port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package `mito_pkg`: layer_type constants (NONE/CONVOLUTION/POOLING/FULLY), fetch state enum, default base addresses.
- Sub-module `fetch_bank` (parameters DEPTH, DATA_W), instantiated three times: register array, write pointer, full flag, flattened read bus.

Test Plan:
- Conv sequence: `ifm_read`, `wgt_read`, `bias_read` pulses, memory ready always, `rsp` 1 cycle later with data = address -> 19 requests at 0x0000–0x0008, 0x0400–0x0408, 0x0800; then `input_load` -> `op_valid`=1, `op_ifm` word k = k, `op_bias`=0x0800, `op_layer_type`=01.
- Backpressure: `mem_req_ready` low 5 cycles on word 3 -> address held stable, `stall_cnt`=5 (macro on); `op_ready` low 4 cycles -> `op_valid` and data held, drop 1 cycle after accept.
- Pool: layer_type=10, only `ifm_read` plus `wgt_read` edge -> no 0x04xx requests; `input_load` presents with `op_wgt`=0, `op_bias`=0.
- Simultaneous `ifm_read` and `bias_read` edges -> IFM burst first, bias next; `input_load` before weights full -> `err`=1, no `op_valid`.
- Reset asserted mid-IFM burst at word 4 -> `mem_req_valid`=0 same cycle, `busy`=0, `err`=0; a fresh burst restarts at 0x0000.
- Address wrap: IFM_BASE=16'hFFFC -> addresses FFFC..FFFF, 0000..0004.
